// File: rtl/valid_accumulator.sv
// Lane-masked OR reduction of LANES valid vectors, two-stage pipeline with
// optional sticky accumulation across a frame and valid/ready output.
module valid_accumulator #(
    parameter int LANES = 32,
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH-1:0]       din,
    input  logic [LANES-1:0]             lane_mask,
    input  logic                         mode,
    input  logic                         frame_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(WIDTH+1)-1:0]   out_count,
    output logic [CNT_W-1:0]             out_beats
);

    localparam int NG = LANES / GROUP;
    localparam int CW = $clog2(WIDTH + 1);

    logic                      w_en;
    logic                      w_emit;
    logic [NG-1:0][WIDTH-1:0]  w_part;
    logic [WIDTH-1:0]          w_b;
    logic [WIDTH-1:0]          w_merged;
    logic [CNT_W-1:0]          w_n;

    logic [NG-1:0][WIDTH-1:0]  r_a_part;
    logic                      r_a_valid;
    logic                      r_a_mode;
    logic                      r_a_last;
    logic [WIDTH-1:0]          r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_out_valid;
    logic [WIDTH-1:0]          r_dout;
    logic [CW-1:0]             r_count;
    logic [CNT_W-1:0]          r_beats;

    function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // The whole pipeline advances only when the output register can take a result.
    assign w_en     = !(r_out_valid && !out_ready);
    assign in_ready = w_en && !clear;

    always_comb begin
        w_part = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            for (int unsigned k = 0; k < GROUP; k++) begin
                w_part[g] = w_part[g] |
                    (din[(g*GROUP+k)*WIDTH +: WIDTH] & {WIDTH{lane_mask[g*GROUP+k]}});
            end
        end
    end

    always_comb begin
        w_b = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            w_b = w_b | r_a_part[g];
        end
    end

    assign w_merged = r_acc | w_b;
    assign w_n      = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    // A mode-0 beat also flushes anything a preceding mode-1 run left in r_acc.
    assign w_emit   = !r_a_mode || r_a_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_part    <= '0;
            r_a_valid   <= 1'b0;
            r_a_mode    <= 1'b0;
            r_a_last    <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_count     <= '0;
            r_beats     <= '0;
        end else if (clear) begin
            r_a_valid   <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_part <= w_part;
                r_a_mode <= mode;
                r_a_last <= frame_last;
            end
            r_out_valid <= r_a_valid && w_emit;
            if (r_a_valid) begin
                if (w_emit) begin
                    r_dout  <= w_merged;
                    r_count <= popcnt(w_merged);
                    r_beats <= w_n;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc   <= w_merged;
                    r_cnt   <= w_n;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign out_count = r_count;
    assign out_beats = r_beats;

endmodule

// File: tb/tb_valid_accumulator.sv
// Directed bench for valid_accumulator: default, small and wide parameter sets.
module tb_valid_accumulator;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] din;
    logic [31:0]   lane_mask;
    logic          mode;
    logic          frame_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   dout;
    logic [5:0]    out_count;
    logic [15:0]   out_beats;

    logic          s_in_valid, s_in_ready, s_out_valid;
    logic [31:0]   s_din;
    logic [3:0]    s_mask;
    logic [7:0]    s_dout;
    logic [3:0]    s_count;
    logic [15:0]   s_beats;

    logic          l_in_valid, l_in_ready, l_out_valid;
    logic [2047:0] l_din;
    logic [63:0]   l_mask;
    logic [31:0]   l_dout;
    logic [5:0]    l_count;
    logic [15:0]   l_beats;

    int n_cmp = 0;
    int n_bad = 0;

    valid_accumulator dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .lane_mask(lane_mask), .mode(mode), .frame_last(frame_last),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .out_count(out_count), .out_beats(out_beats)
    );

    valid_accumulator #(.LANES(4), .WIDTH(8), .GROUP(2), .CNT_W(16)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .din(s_din), .lane_mask(s_mask), .mode(mode), .frame_last(frame_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .dout(s_dout),
        .out_count(s_count), .out_beats(s_beats)
    );

    valid_accumulator #(.LANES(64), .WIDTH(32), .GROUP(16), .CNT_W(16)) dut_l (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .din(l_din), .lane_mask(l_mask), .mode(mode), .frame_last(frame_last),
        .out_valid(l_out_valid), .out_ready(out_ready), .dout(l_dout),
        .out_count(l_count), .out_beats(l_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic l);
        in_valid   = 1'b1;
        mode       = m;
        frame_last = l;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0; l_in_valid = 1'b0;
        din = '0; lane_mask = '0; mode = 1'b0; frame_last = 1'b0; out_ready = 1'b1;
        s_din = '0; s_mask = '0; l_din = '0; l_mask = '0;
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL rst_dout got %h want 0", dout); end
        n_cmp++; if (out_count !== 6'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", out_count); end
        n_cmp++; if (out_beats !== 16'd0) begin n_bad++; $display("FAIL rst_beats got %0d want 0", out_beats); end
        #4 rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_mode0();
        din = '0;
        din[3*32 +: 32]  = 32'h0000_0001;
        din[31*32 +: 32] = 32'h8000_0000;
        lane_mask = '1;
        send(1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL m0_early_valid got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL m0_valid got %b want 1", out_valid); end
        n_cmp++; if (dout !== 32'h8000_0001) begin n_bad++; $display("FAIL m0_dout got %h want 80000001", dout); end
        n_cmp++; if (out_count !== 6'd2) begin n_bad++; $display("FAIL m0_count got %0d want 2", out_count); end
        n_cmp++; if (out_beats !== 16'd1) begin n_bad++; $display("FAIL m0_beats got %0d want 1", out_beats); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL m0_drop got %b want 0", out_valid); end
    endtask

    task automatic test_mask();
        lane_mask[31] = 1'b0;
        send(1'b0, 1'b0);
        tick();
        n_cmp++; if (dout !== 32'h0000_0001) begin n_bad++; $display("FAIL mask_dout got %h want 00000001", dout); end
        n_cmp++; if (out_count !== 6'd1) begin n_bad++; $display("FAIL mask_count got %0d want 1", out_count); end
        lane_mask = '0;
        send(1'b0, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mask0_valid got %b want 1", out_valid); end
        n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL mask0_dout got %h want 0", dout); end
        n_cmp++; if (out_beats !== 16'd1) begin n_bad++; $display("FAIL mask0_beats got %0d want 1", out_beats); end
        tick();
    endtask

    task automatic test_accumulate();
        din = '0; lane_mask = '1;
        din[31:0] = 32'h1; send(1'b1, 1'b0);
        din[31:0] = 32'h2; send(1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL acc_b1_valid got %b want 0", out_valid); end
        din[31:0] = 32'h4; send(1'b1, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL acc_b2_valid got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL acc_valid got %b want 1", out_valid); end
        n_cmp++; if (dout !== 32'h7) begin n_bad++; $display("FAIL acc_dout got %h want 7", dout); end
        n_cmp++; if (out_count !== 6'd3) begin n_bad++; $display("FAIL acc_count got %0d want 3", out_count); end
        n_cmp++; if (out_beats !== 16'd3) begin n_bad++; $display("FAIL acc_beats got %0d want 3", out_beats); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL acc_drop got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] prev;
        logic        holding;
        int          sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0; holding = 1'b0; prev = '0;
        din = '0; lane_mask = '1; mode = 1'b0; frame_last = 1'b0;
        while (recv < 8 && cyc < 60) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 8);
            din[31:0] = 32'(sent + 1);
            #1;
            if (out_valid && !out_ready) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
                if (holding) begin
                    n_cmp++; if (dout !== prev) begin n_bad++; $display("FAIL bp_hold got %h want %h", dout, prev); end
                end
                holding = 1'b1;
                prev    = dout;
            end else begin
                holding = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL bp_extra got %h want none", dout);
                end else begin
                    if (dout !== q[0]) begin n_bad++; $display("FAIL bp_order got %h want %h", dout, q[0]); end
                    void'(q.pop_front());
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(32'(sent + 1));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (recv != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", recv); end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL bp_pending got %0d want 0", q.size()); end
        tick();
    endtask

    task automatic test_switch_and_clear();
        din = '0; lane_mask = '1;
        din[31:0] = 32'h10; send(1'b1, 1'b0);
        din[31:0] = 32'h20; send(1'b1, 1'b0);
        din[31:0] = 32'h01; send(1'b0, 1'b0);
        tick();
        n_cmp++; if (dout !== 32'h31) begin n_bad++; $display("FAIL sw_dout got %h want 31", dout); end
        n_cmp++; if (out_beats !== 16'd3) begin n_bad++; $display("FAIL sw_beats got %0d want 3", out_beats); end
        n_cmp++; if (out_count !== 6'd3) begin n_bad++; $display("FAIL sw_count got %0d want 3", out_count); end
        tick();
        din[31:0] = 32'h10; send(1'b1, 1'b0);
        din[31:0] = 32'h20; send(1'b1, 1'b0);
        clear = 1'b1; in_valid = 1'b1; mode = 1'b0; din[31:0] = 32'h40;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_in_ready got %b want 0", in_ready); end
        tick();
        clear = 1'b0; in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid1 got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid2 got %b want 0", out_valid); end
        din[31:0] = 32'h08; send(1'b1, 1'b1);
        tick();
        n_cmp++; if (dout !== 32'h08) begin n_bad++; $display("FAIL clr_next_dout got %h want 08", dout); end
        n_cmp++; if (out_beats !== 16'd1) begin n_bad++; $display("FAIL clr_next_beats got %0d want 1", out_beats); end
        tick();
    endtask

    task automatic test_reset_midframe();
        din = '0; lane_mask = '1;
        din[31:0] = 32'h10; send(1'b1, 1'b0);
        din[31:0] = 32'h20; send(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (dout !== 32'h0) begin n_bad++; $display("FAIL rmf_dout got %h want 0", dout); end
        n_cmp++; if (out_beats !== 16'd0) begin n_bad++; $display("FAIL rmf_beats got %0d want 0", out_beats); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmf_valid got %b want 0", out_valid); end
        #3 rst_n = 1'b1;
        tick();
        din[31:0] = 32'h04; send(1'b1, 1'b1);
        tick();
        n_cmp++; if (dout !== 32'h04) begin n_bad++; $display("FAIL rmf_next_dout got %h want 04", dout); end
        n_cmp++; if (out_beats !== 16'd1) begin n_bad++; $display("FAIL rmf_next_beats got %0d want 1", out_beats); end
        tick();
    endtask

    task automatic test_param_sweep();
        s_din  = {8'h02, 8'h10, 8'h80, 8'h01};
        s_mask = 4'b1011;
        l_din  = '0;
        l_din[63*32 +: 32] = 32'h8000_0000;
        l_din[17*32 +: 32] = 32'h0001_0000;
        l_din[40*32 +: 32] = 32'h0000_000F;
        l_mask = '1;
        l_mask[40] = 1'b0;
        mode = 1'b0; frame_last = 1'b0;
        s_in_valid = 1'b1; l_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0; l_in_valid = 1'b0;
        tick();
        n_cmp++; if (s_out_valid !== 1'b1) begin n_bad++; $display("FAIL s_valid got %b want 1", s_out_valid); end
        n_cmp++; if (s_dout !== 8'h83) begin n_bad++; $display("FAIL s_dout got %h want 83", s_dout); end
        n_cmp++; if (s_count !== 4'd3) begin n_bad++; $display("FAIL s_count got %0d want 3", s_count); end
        n_cmp++; if (s_beats !== 16'd1) begin n_bad++; $display("FAIL s_beats got %0d want 1", s_beats); end
        n_cmp++; if (l_out_valid !== 1'b1) begin n_bad++; $display("FAIL l_valid got %b want 1", l_out_valid); end
        n_cmp++; if (l_dout !== 32'h8001_0000) begin n_bad++; $display("FAIL l_dout got %h want 80010000", l_dout); end
        n_cmp++; if (l_count !== 6'd2) begin n_bad++; $display("FAIL l_count got %0d want 2", l_count); end
        n_cmp++; if (l_beats !== 16'd1) begin n_bad++; $display("FAIL l_beats got %0d want 1", l_beats); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mask();
        test_accumulate();
        test_back_to_back();
        test_switch_and_clear();
        test_reset_midframe();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
